// File: rtl/brush_stamp_ctrl_pkg.sv
// Shared paint definitions: canvas geometry, colour codes, paint states.
package brush_stamp_ctrl_pkg;

    localparam int CANVAS_W = 160;
    localparam int CANVAS_H = 120;
    localparam int ADDR_W   = 15;
    localparam int COLOR_W  = 3;
    localparam int BRUSH_S  = 1;
    localparam int BRUSH_L  = 5;
    localparam int NPIX     = CANVAS_W * CANVAS_H;
    localparam int RAD_W    = 3;
    localparam int OFS_W    = 4;

    localparam logic [COLOR_W-1:0] COL_BLACK  = 3'b000;
    localparam logic [COLOR_W-1:0] COL_BLUE   = 3'b001;
    localparam logic [COLOR_W-1:0] COL_GREEN  = 3'b010;
    localparam logic [COLOR_W-1:0] COL_CYAN   = 3'b011;
    localparam logic [COLOR_W-1:0] COL_RED    = 3'b100;
    localparam logic [COLOR_W-1:0] COL_PURPLE = 3'b101;
    localparam logic [COLOR_W-1:0] COL_YELLOW = 3'b110;
    localparam logic [COLOR_W-1:0] COL_WHITE  = 3'b111;
    localparam logic [COLOR_W-1:0] BG_COLOR   = COL_WHITE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STAMP,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic [7:0]         x;
        logic [6:0]         y;
        logic               big;
        logic [COLOR_W-1:0] col;
    } sample_t;

    function automatic logic [RAD_W-1:0] radius_of(input logic big);
        return big ? RAD_W'((BRUSH_L - 1) / 2) : RAD_W'((BRUSH_S - 1) / 2);
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [9:0] x,
        input logic [8:0] y
    );
        return ADDR_W'(y) * ADDR_W'(CANVAS_W) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/brush_point_gen.sv
// Raster walk over a square brush footprint around a centre point,
// flagging points that fall outside the canvas.
module brush_point_gen
    import brush_stamp_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             advance,
    input  logic [7:0]       cx,
    input  logic [6:0]       cy,
    input  logic [RAD_W-1:0] radius,
    output logic [9:0]       px,
    output logic [8:0]       py,
    output logic             in_bounds,
    output logic             last
);

    logic [OFS_W-1:0] ox;
    logic [OFS_W-1:0] oy;
    logic [OFS_W-1:0] span;

    assign span = OFS_W'({radius, 1'b0});

    always_ff @(posedge clk) begin
        if (clr || load) begin
            ox <= '0;
            oy <= '0;
        end else if (advance) begin
            if (ox == span) begin
                ox <= '0;
                oy <= oy + 1'b1;
            end else begin
                ox <= ox + 1'b1;
            end
        end
    end

    // Offsets are unsigned 0..2r; subtracting r gives the signed position,
    // and a set MSB means the point lies left of / above the canvas.
    assign px = 10'(cx) + 10'(ox) - 10'(radius);
    assign py = 9'(cy) + 9'(oy) - 9'(radius);

    assign in_bounds = !px[9] && (px < 10'(CANVAS_W))
                    && !py[8] && (py < 9'(CANVAS_H));
    assign last = (ox == span) && (oy == span);

endmodule

// File: rtl/brush_stamp_ctrl.sv
// Paint write sequencer: turns cursor samples into clipped brush stamps
// and runs canvas clears through the shared framebuffer write port.
module brush_stamp_ctrl
    import brush_stamp_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               tool_on,
    input  logic               size_sel,
    input  logic [COLOR_W-1:0] color,
    input  logic [7:0]         cur_x,
    input  logic [6:0]         cur_y,
    input  logic               cur_valid,
    input  logic               clear_req,
    input  logic               fb_gnt,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_wdata,
    output logic               busy
);

    state_t             state;
    state_t             state_nx;
    sample_t            new_s;
    sample_t            pend;
    sample_t            stamp;
    sample_t            last;
    logic               pend_v;
    logic               last_v;
    logic               clr_flag;
    logic [ADDR_W-1:0]  clr_cnt;
    logic               take;
    logic               start_stamp;
    logic               start_clear;
    logic               drop;
    logic               adv;
    logic               stamp_done;
    logic               clear_done;
    logic [9:0]         px;
    logic [8:0]         py;
    logic               in_b;
    logic               pt_last;

    assign new_s = '{x: cur_x, y: cur_y, big: size_sel, col: color};
    assign take  = cur_valid && tool_on;
    assign busy  = (state != ST_IDLE);

    brush_point_gen u_pgen (
        .clk       (clk),
        .clr       (clr),
        .load      (start_stamp),
        .advance   (adv),
        .cx        (stamp.x),
        .cy        (stamp.y),
        .radius    (radius_of(stamp.big)),
        .px        (px),
        .py        (py),
        .in_bounds (in_b),
        .last      (pt_last)
    );

    always_comb begin
        state_nx    = state;
        start_stamp = 1'b0;
        start_clear = 1'b0;
        drop        = 1'b0;
        adv         = 1'b0;
        stamp_done  = 1'b0;
        clear_done  = 1'b0;
        fb_we       = 1'b0;
        fb_addr     = '0;
        fb_wdata    = '0;
        unique case (state)
            ST_IDLE: begin
                if (clr_flag) begin
                    state_nx    = ST_CLEAR;
                    start_clear = 1'b1;
                end else if (pend_v) begin
                    if (last_v && (pend == last)) begin
                        drop = 1'b1;
                    end else begin
                        state_nx    = ST_STAMP;
                        start_stamp = 1'b1;
                    end
                end
            end
            ST_STAMP: begin
                fb_addr  = pix_addr(px, py);
                fb_wdata = stamp.col;
                fb_we    = in_b && fb_gnt;
                // Clipped points never need the port, so they cost one cycle.
                adv      = in_b ? fb_gnt : 1'b1;
                if (adv && pt_last) begin
                    stamp_done = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                fb_addr  = clr_cnt;
                fb_wdata = BG_COLOR;
                fb_we    = fb_gnt;
                if (fb_gnt && (clr_cnt == ADDR_W'(NPIX - 1))) begin
                    clear_done = 1'b1;
                    state_nx   = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= ST_IDLE;
            pend     <= '0;
            stamp    <= '0;
            last     <= '0;
            pend_v   <= 1'b0;
            last_v   <= 1'b0;
            clr_flag <= 1'b0;
            clr_cnt  <= '0;
        end else begin
            state <= state_nx;
            // A sample arriving as the old one is consumed must survive.
            if (take) begin
                pend   <= new_s;
                pend_v <= 1'b1;
            end else if (start_stamp || drop) begin
                pend_v <= 1'b0;
            end
            if (start_stamp) begin
                stamp <= pend;
            end
            if (clear_req) begin
                clr_flag <= 1'b1;
            end else if (start_clear) begin
                clr_flag <= 1'b0;
            end
            if (start_clear) begin
                clr_cnt <= '0;
            end else if ((state == ST_CLEAR) && fb_gnt) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (stamp_done) begin
                last   <= stamp;
                last_v <= 1'b1;
            end else if (clear_done) begin
                last_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_brush_stamp_ctrl.sv
// Bench for brush_stamp_ctrl: stamp table, hand-written corner sequences
// and random samples against a footprint model.
module tb_brush_stamp_ctrl;

    localparam int W = 160;
    localparam int H = 120;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        tool_on = 1'b1;
    logic        size_sel = 1'b0;
    logic [2:0]  color = '0;
    logic [7:0]  cur_x = '0;
    logic [6:0]  cur_y = '0;
    logic        cur_valid = 1'b0;
    logic        clear_req = 1'b0;
    logic        fb_gnt = 1'b1;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        busy;

    brush_stamp_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .tool_on   (tool_on),
        .size_sel  (size_sel),
        .color     (color),
        .cur_x     (cur_x),
        .cur_y     (cur_y),
        .cur_valid (cur_valid),
        .clear_req (clear_req),
        .fb_gnt    (fb_gnt),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   wr_q[$];
    int   exp_q[$];
    int   busy_cnt = 0;
    logic rnd_gnt = 1'b0;

    always @(negedge clk) begin
        if (fb_we) wr_q.push_back(int'(fb_addr) * 8 + int'(fb_wdata));
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    typedef struct {
        int x; int y; int big; int col;
        int n; int first; int last; int bcyc;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_gnt) fb_gnt = ($urandom_range(3) != 0);
        #1;
    endtask

    task automatic send(input int x, input int y, input int big, input int col);
        cur_x     = 8'(x);
        cur_y     = 7'(y);
        size_sel  = big[0];
        color     = 3'(col);
        cur_valid = 1'b1;
        tick();
        cur_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int idle = 0;
        int n = 0;
        while (idle < 3 && n < bound) begin
            tick();
            n++;
            if (!busy) idle++;
            else idle = 0;
        end
        if (idle < 3) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", n);
        end
    endtask

    // Footprint model: every in-canvas pixel of the square, raster order.
    function automatic void build(input int x, input int y, input int big, input int col);
        int r = big ? 2 : 0;
        for (int dy = -r; dy <= r; dy++)
            for (int dx = -r; dx <= r; dx++) begin
                int px = x + dx;
                int py = y + dy;
                if (px >= 0 && px < W && py >= 0 && py < H)
                    exp_q.push_back((py * W + px) * 8 + col);
            end
    endfunction

    task automatic cmp_q(input string name);
        int bad = 0;
        int n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        check({name, ".count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < n; i++)
            if (wr_q[i] != exp_q[i]) bad++;
        check({name, ".seq"}, bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lv;
        int lx, ly, lb, lc;
        int sx, sy, sb, sc;

        tbl[0] = '{0,   0,   1, 1, 9,  0,     322,   25};
        tbl[1] = '{159, 119, 1, 4, 9,  18877, 19199, 25};
        tbl[2] = '{80,  60,  1, 3, 25, 9358,  10002, 25};
        tbl[3] = '{2,   50,  1, 5, 25, 7680,  8324,  25};
        tbl[4] = '{1,   0,   1, 6, 12, 0,     323,   25};
        tbl[5] = '{200, 50,  1, 2, 0,  0,     0,     25};
        tbl[6] = '{159, 0,   0, 7, 1,  159,   159,   1};
        tbl[7] = '{0,   119, 0, 0, 1,  19040, 19040, 1};

        tick();
        tick();
        check("rst.we", int'(fb_we), 0);
        check("rst.busy", int'(busy), 0);
        check("rst.addr", int'(fb_addr), 0);
        check("rst.wdata", int'(fb_wdata), 0);
        clr = 1'b0;
        tick();

        // Small stamp latency and single write
        wr_q.delete();
        send(10, 10, 0, 2);
        check("small.idle_after_valid", int'(busy), 0);
        tick();
        check("small.busy", int'(busy), 1);
        check("small.we", int'(fb_we), 1);
        check("small.addr", int'(fb_addr), 1610);
        check("small.wdata", int'(fb_wdata), 2);
        tick();
        check("small.done", int'(busy), 0);
        wait_idle(20);
        check("small.nwr", wr_q.size(), 1);

        foreach (tbl[i]) begin
            wr_q.delete();
            busy_cnt = 0;
            send(tbl[i].x, tbl[i].y, tbl[i].big, tbl[i].col);
            wait_idle(100);
            check($sformatf("tbl%0d.nwr", i), wr_q.size(), tbl[i].n);
            if (tbl[i].n > 0 && wr_q.size() > 0) begin
                check($sformatf("tbl%0d.first", i), wr_q[0] / 8, tbl[i].first);
                check($sformatf("tbl%0d.last", i), wr_q[$] / 8, tbl[i].last);
            end
            check($sformatf("tbl%0d.busy_cycles", i), busy_cnt, tbl[i].bcyc);
            exp_q.delete();
            build(tbl[i].x, tbl[i].y, tbl[i].big, tbl[i].col);
            cmp_q($sformatf("tbl%0d", i));
        end

        // Grant stall holds the point
        wr_q.delete();
        fb_gnt = 1'b0;
        send(5, 5, 0, 4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("stall%0d.busy", k), int'(busy), 1);
            check($sformatf("stall%0d.we", k), int'(fb_we), 0);
            check($sformatf("stall%0d.addr", k), int'(fb_addr), 805);
        end
        fb_gnt = 1'b1;
        #1;
        check("stall.gnt_we", int'(fb_we), 1);
        check("stall.gnt_addr", int'(fb_addr), 805);
        tick();
        check("stall.done", int'(busy), 0);
        wait_idle(20);
        check("stall.nwr", wr_q.size(), 1);

        // Overwritten buffer, dedup, tool off
        wr_q.delete();
        send(40, 40, 1, 1);
        tick();
        send(30, 30, 1, 4);
        tick();
        send(25, 25, 0, 5);
        tick();
        send(20, 30, 0, 3);
        wait_idle(100);
        exp_q.delete();
        build(40, 40, 1, 1);
        build(20, 30, 0, 3);
        cmp_q("buffer");
        wr_q.delete();
        send(20, 30, 0, 3);
        wait_idle(50);
        check("dedup.nwr", wr_q.size(), 0);
        tool_on = 1'b0;
        send(70, 70, 1, 2);
        wait_idle(50);
        check("tool_off.nwr", wr_q.size(), 0);
        tool_on = 1'b1;

        // Clear requested mid-stamp runs after the stamp
        wr_q.delete();
        send(80, 60, 1, 6);
        tick();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_idle(20100);
        exp_q.delete();
        build(80, 60, 1, 6);
        for (int a = 0; a < W * H; a++) exp_q.push_back(a * 8 + 7);
        cmp_q("clear");
        check("clear.busy_end", int'(busy), 0);
        wr_q.delete();
        send(80, 60, 1, 6);
        wait_idle(100);
        check("post_clear.nwr", wr_q.size(), 25);

        // Reset in the third stamp cycle
        wr_q.delete();
        send(50, 50, 1, 2);
        tick();
        tick();
        tick();
        clr = 1'b1;
        tick();
        check("rst_mid.we", int'(fb_we), 0);
        check("rst_mid.busy", int'(busy), 0);
        clr = 1'b0;
        tick();
        tick();
        check("rst_mid.nwr", wr_q.size(), 3);
        wr_q.delete();
        send(50, 50, 1, 2);
        wait_idle(100);
        check("rst_mid.restamp", wr_q.size(), 25);

        // Random samples with random grant
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        lv = 0;
        lx = 0; ly = 0; lb = 0; lc = 0;
        rnd_gnt = 1'b1;
        for (int it = 0; it < 60; it++) begin
            if (lv != 0 && $urandom_range(3) == 0) begin
                sx = lx; sy = ly; sb = lb; sc = lc;
            end else begin
                sx = $urandom_range(167);
                sy = $urandom_range(127);
                sb = $urandom_range(1);
                sc = $urandom_range(7);
            end
            wr_q.delete();
            exp_q.delete();
            if (!(lv != 0 && sx == lx && sy == ly && sb == lb && sc == lc))
                build(sx, sy, sb, sc);
            send(sx, sy, sb, sc);
            wait_idle(400);
            cmp_q($sformatf("rnd%0d", it));
            lv = 1;
            lx = sx; ly = sy; lb = sb; lc = sc;
        end
        rnd_gnt = 1'b0;
        fb_gnt = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/brush_stamp_ctrl.md
Name: brush_stamp_ctrl

Overview:
- Sequences all paint writes into the canvas framebuffer.
- When the tool is on, converts each joystick cursor sample into a square brush stamp (small/large, selected colour), clipped to the canvas.
- Runs a full-canvas clear on request.
- Shares the single framebuffer write port with the VGA scan-out side through a grant signal; sits between the joystick/colour/control logic and the framebuffer.

Parameters:
- CANVAS_W, 160, canvas width in pixels.
- CANVAS_H, 120, canvas height in pixels.
- ADDR_W, 15, framebuffer address width (CANVAS_W*CANVAS_H must be ≤ 2^ADDR_W).
- COLOR_W, 3, colour code width.
- BRUSH_S, 1, small brush side (odd).
- BRUSH_L, 5, large brush side (odd).
- BG_COLOR, 3'b111, colour written by clear.

Ports:
- clk  in  1  system clock.
- clr  in  1  synchronous active-high reset.
- tool_on  in  1  level; painting enabled.
- size_sel  in  1  level; 0 = BRUSH_S, 1 = BRUSH_L.
- color  in  COLOR_W  current paint colour.
- cur_x  in  8  cursor x, canvas pixels.
- cur_y  in  7  cursor y, canvas pixels.
- cur_valid  in  1  one-cycle pulse per new cursor sample.
- clear_req  in  1  one-cycle pulse; wipe the canvas.
- fb_gnt  in  1  framebuffer write port available this cycle.
- fb_we  out  1  write strobe.
- fb_addr  out  ADDR_W  write address = y*CANVAS_W + x.
- fb_wdata  out  COLOR_W  write colour.
- busy  out  1  high in STAMP or CLEAR.

Behaviour:
- Reset: on clk edge with clr=1.
  - State → IDLE.
  - fb_we=0, fb_addr=0, fb_wdata=0, busy=0.
  - Pending sample and pending clear cleared; last-stamp record invalid.
  - Applies mid-stamp or mid-clear; no further writes after that edge.
- States: IDLE, STAMP, CLEAR.
- Sample buffer: one entry holding x, y, size, colour.
  - Loaded on cur_valid when tool_on=1.
  - A newer sample overwrites an unserved one.
  - cur_valid with tool_on=0 is ignored.
- Clear flag: set by clear_req in any state; cleared when CLEAR is entered.
- IDLE transitions, evaluated each cycle, priority order:
  - Clear flag set → CLEAR.
  - Sample pending and not equal to the last completed stamp (x, y, size, colour all equal) → STAMP.
  - Sample pending and equal to the last completed stamp → drop it, stay IDLE.
- STAMP:
  - Latch the sample on entry; r = (side-1)/2.
  - Raster-scan dy = -r..r (outer loop), dx = -r..r (inner loop).
  - Point px = x+dx, py = y+dy, computed signed with 1 extra bit.
  - In bounds iff 0 ≤ px < CANVAS_W and 0 ≤ py < CANVAS_H.
  - In-bounds point: fb_we = fb_gnt; advance only when fb_gnt=1; otherwise hold, outputs stable.
  - Out-of-bounds point: fb_we=0; advance unconditionally (1 cycle).
  - After the last point: record the last stamp, go IDLE.
  - Stamp duration = side² cycles + stall cycles.
- CLEAR:
  - addr 0..CANVAS_W*CANVAS_H-1 ascending, fb_wdata=BG_COLOR.
  - Advance only on fb_gnt.
  - At end: invalidate the last-stamp record, go IDLE.
- Outputs:
  - fb_we, fb_addr, fb_wdata are combinational from registered counters and fb_gnt.
  - fb_addr and fb_wdata are valid whenever busy=1.
  - fb_we=0 whenever busy=0.
- Latency: first write in the cycle after the IDLE→STAMP transition; IDLE→STAMP occurs the cycle after cur_valid.
- Input changes:
  - tool_on dropping mid-stamp does not abort the stamp.
  - size_sel and color changes apply only to new samples.
- Arithmetic: address via y*CANVAS_W + x with a constant multiplier, truncated to ADDR_W; no wrap possible under the parameter constraint.

Decomposition:
- Shared paint package holds:
  - state encoding (IDLE/STAMP/CLEAR);
  - CANVAS_W/H, COLOR_W, BG_COLOR;
  - colour code constants shared with the colour selector.
- One sub-module, brush_point_gen:
  - inputs: centre, radius, advance;
  - outputs: px/py, in_bounds, last.
  - Reused by STAMP; CLEAR uses a plain counter.

Test Plan:
- Small stamp:
  - Stimulus: tool_on=1, size_sel=0, color=3'b010, cur_valid at (10,10), fb_gnt=1.
  - Response: exactly one write, addr 1610, data 010; busy high 1 cycle.
- Corner clip:
  - Stimulus: size_sel=1 at (0,0).
  - Response: 25 scan cycles, 9 writes, addrs 0,1,2,160,161,162,320,321,322 in that order.
- Grant stall:
  - Stimulus: small stamp at (5,5), fb_gnt low for 4 cycles then high.
  - Response: fb_addr=805 held stable, single fb_we pulse on the grant cycle.
- Clear with deferred request:
  - Stimulus: clear_req during a large stamp.
  - Response: stamp completes, then 19200 writes addr 0..19199 data 111, then busy=0.
- Buffer and dedup:
  - Stimulus: three cur_valid during a stamp, last at (20,30); then a repeat of (20,30).
  - Response: only (20,30) is stamped next, addr 4820 centre; the repeat produces no writes.
- Reset mid-stamp:
  - Stimulus: clr at the 3rd cycle of a large stamp.
  - Response: fb_we=0 and busy=0 from the next cycle; a subsequent same-position sample stamps again.
